restoring_divider: RTL and testbench



---
 rtl/restoring_divider_pkg.sv | 24 ++
 rtl/restoring_divider_if.sv | 26 ++
 rtl/restoring_divider_sub_ripple_n.sv | 24 ++
 rtl/restoring_divider.sv | 135 +++++++++++++
 tb/tb_restoring_divider.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/restoring_divider_pkg.sv
// Shared types and constants for the restoring divider: FSM state encoding
// and the iteration counter sizing rule.
package div_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_CALC = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_t;

    // One extra bit over clog2 keeps the iteration count from ever wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(4);

endpackage

// File: rtl/restoring_divider_if.sv
// Start/operand/result bundle between a divide requester (master) and the
// restoring divider (slave).
interface restoring_divider_if #(
    parameter int WIDTH = 4
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/restoring_divider_sub_ripple_n.sv
// N-bit borrow-ripple subtractor: D = A - B - Kin, Kout is the final borrow.
// Each stage's borrow feeds only the next stage up.
module sub_ripple_n #(
    parameter int N = 5
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Kin,
    output logic [N-1:0] D,
    output logic         Kout
);

    logic [N:0] borrow_s;

    assign borrow_s[0] = Kin;

    for (genvar i = 0; i < N; i++) begin : g_stage
        assign D[i]          = A[i] ^ B[i] ^ borrow_s[i];
        assign borrow_s[i+1] = (~A[i] & B[i]) | (borrow_s[i] & ~(A[i] ^ B[i]));
    end

    assign Kout = borrow_s[N];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock,
// MSB first, with a dedicated divide-by-zero shortcut.
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    restoring_divider_if.slave  bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_r;
    logic [WIDTH-1:0]   dvd_r;
    logic [WIDTH-1:0]   dvs_r;
    logic [WIDTH:0]     rem_r;
    logic [WIDTH-1:0]   q_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   quotient_r;
    logic [WIDTH-1:0]   remainder_r;
    logic               dbz_r;
    logic               busy_r;
    logic               done_r;

    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     diff_s;
    logic               kout_s;
    logic [WIDTH:0]     rem_next_s;
    logic [WIDTH-1:0]   q_next_s;
    logic               last_s;

    sub_ripple_n #(
        .N(WIDTH + 1)
    ) u_sub (
        .A    (shifted_s),
        .B    ({1'b0, dvs_r}),
        .Kin  (1'b0),
        .D    (diff_s),
        .Kout (kout_s)
    );

    // Next partial remainder and quotient for the current iteration.
    always_comb begin
        shifted_s  = '0;
        rem_next_s = '0;
        q_next_s   = '0;
        last_s     = 1'b0;

        // Bring down the next dividend bit; the top remainder bit falls off.
        shifted_s = (WIDTH+1)'({rem_r, dvd_r[WIDTH-1]});
        if (kout_s) begin
            rem_next_s = shifted_s;
        end else begin
            rem_next_s = diff_s;
        end
        q_next_s = WIDTH'({q_r, ~kout_s});
        last_s   = (cnt_r == CNT_W'(WIDTH - 1));
    end

    // Control FSM with its datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            dvd_r       <= '0;
            dvs_r       <= '0;
            rem_r       <= '0;
            q_r         <= '0;
            cnt_r       <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        dvd_r  <= bus.dividend;
                        dvs_r  <= bus.divisor;
                        rem_r  <= '0;
                        q_r    <= '0;
                        cnt_r  <= '0;
                        busy_r <= 1'b1;
                        if (bus.divisor == '0) begin
                            quotient_r  <= '1;
                            remainder_r <= bus.dividend;
                            dbz_r       <= 1'b1;
                            done_r      <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            state_r <= CALC;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                CALC: begin
                    rem_r <= rem_next_s;
                    q_r   <= q_next_s;
                    dvd_r <= dvd_r << 1;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        quotient_r  <= q_next_s;
                        remainder_r <= WIDTH'(rem_next_s);
                        dbz_r       <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (WIDTH=4) against plain integer
// division, plus an exhaustive check of the borrow-ripple subtractor.
module tb_restoring_divider;

    localparam int W = 4;
    localparam int ALL_ONES = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    restoring_divider_if #(.WIDTH(W)) bus ();

    restoring_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [W:0] sa, sb, sd;
    logic       skin, skout;

    sub_ripple_n #(.N(W + 1)) u_sub (
        .A    (sa),
        .B    (sb),
        .Kin  (skin),
        .D    (sd),
        .Kout (skout)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_pulses = 0;

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ref_div(input int a, input int b, output int q, output int r, output int z);
        if (b == 0) begin
            q = ALL_ONES; r = a; z = 1;
        end else begin
            q = a / b; r = a % b; z = 0;
        end
    endtask

    task automatic launch(input int a, input int b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a[W-1:0];
        bus.divisor  = b[W-1:0];
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
    endtask

    // Returns edges elapsed after the start edge when done is seen, or -1.
    task automatic wait_done(output int lat, output int busy_n);
        lat = -1;
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busy_n++;
            if (bus.done === 1'b1) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic run_div(input int a, input int b);
        int lat, bn, q, r, z, exp_lat;
        string t;
        t = $sformatf("%0d/%0d", a, b);
        ref_div(a, b, q, r, z);
        exp_lat = (b == 0) ? 0 : W;
        launch(a, b);
        wait_done(lat, bn);
        check_eq({t, " latency"}, lat, exp_lat);
        check_eq({t, " busy cycles"}, bn, exp_lat + 1);
        check_eq({t, " quotient"}, bus.quotient, q);
        check_eq({t, " remainder"}, bus.remainder, r);
        check_eq({t, " div_by_zero"}, bus.div_by_zero, z);
        @(negedge clk);
        check_eq({t, " done single pulse"}, bus.done, 0);
        check_eq({t, " busy cleared"}, bus.busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bn, base;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst_n        = 1'b0;
        #12;
        check_eq("reset busy", bus.busy, 0);
        check_eq("reset done", bus.done, 0);
        check_eq("reset quotient", bus.quotient, 0);
        check_eq("reset remainder", bus.remainder, 0);
        check_eq("reset div_by_zero", bus.div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                for (int k = 0; k < 2; k++) begin
                    sa = a[W:0]; sb = b[W:0]; skin = k[0];
                    #1;
                    check_eq($sformatf("sub %0d-%0d-%0d", a, b, k), {26'd0, skout, sd}, (a - b - k) & 63);
                end
            end
        end

        run_div(13, 3);
        run_div(15, 1);
        run_div(15, 15);
        run_div(2, 9);
        run_div(7, 0);
        run_div(6, 2);

        // Starts during CALC and during DONE must be dropped.
        base = done_pulses;
        launch(13, 3);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd9; bus.divisor = 4'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat, bn);
        check_eq("ignore latency", lat, W - 1);
        bus.start = 1'b1; bus.dividend = 4'd9; bus.divisor = 4'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("ignore done count", done_pulses - base, 1);
        check_eq("ignore quotient", bus.quotient, 4);
        check_eq("ignore remainder", bus.remainder, 1);
        check_eq("ignore busy", bus.busy, 0);

        // Asynchronous reset mid-operation.
        launch(14, 3);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        base = done_pulses;
        check_eq("midreset busy", bus.busy, 0);
        check_eq("midreset done", bus.done, 0);
        check_eq("midreset quotient", bus.quotient, 0);
        check_eq("midreset remainder", bus.remainder, 0);
        check_eq("midreset div_by_zero", bus.div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("midreset no done", done_pulses - base, 0);
        check_eq("midreset idle", bus.busy, 0);
        run_div(14, 3);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div(a, b);
            end
        end

        for (int i = 0; i < 40; i++) begin
            run_div(int'($urandom_range(ALL_ONES, 0)), int'($urandom_range(ALL_ONES, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
